deconv_stream_master: RTL and testbench

//  Host-side driver for the deconv2D core: the transmitting end of its load/ready interface.
//  On start, pulses the core's enable, then streams K*K kernel words and N*N image words into it, honouring its ready backpressure.

---
 rtl/deconv_stream_master.sv | 152 +++++++++++++++
 tb/tb_deconv_stream_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/deconv_stream_master.sv
// deconv_stream_master: host-side driver for the deconv2D core.
// Pulses core enable, streams K*K kernel words then N*N image words with
// ready backpressure, captures the core's output grid on done, and then
// serializes that grid row-major on a valid/ready stream.
module deconv_stream_master #(
  parameter int N           = 2,
  parameter int K           = 3,
  parameter int PIXEL_WIDTH = 8,
  parameter int OUT_PIX     = N*K*N*K
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   job_done,
  input  logic                   kern_valid,
  input  logic [PIXEL_WIDTH-1:0] kern_data,
  output logic                   kern_ready,
  input  logic                   img_valid,
  input  logic [PIXEL_WIDTH-1:0] img_data,
  output logic                   img_ready,
  output logic                   core_enable,
  output logic                   load_kernel,
  output logic [PIXEL_WIDTH-1:0] kernel_input,
  input  logic                   kernel_ready,
  output logic                   load_input,
  output logic [PIXEL_WIDTH-1:0] image_input,
  input  logic                   input_ready,
  input  logic                   core_done,
  input  logic [PIXEL_WIDTH-1:0] core_out [0:OUT_PIX-1],
  output logic                   out_valid,
  output logic [PIXEL_WIDTH-1:0] out_data,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int KK   = K*K;
  localparam int NN   = N*N;
  localparam int TMAX = (KK > NN) ? KK : NN;
  localparam int TCW  = $clog2(TMAX + 1);
  localparam int IW   = $clog2(OUT_PIX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_KERNEL,
    S_SEND_IMAGE,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  state_t                 state, state_nxt;
  logic [TCW-1:0]         xfer_cnt;
  logic [IW-1:0]          idx;
  logic [PIXEL_WIDTH-1:0] frame [0:OUT_PIX-1];
  logic                   capture;
  logic                   last_beat;
  logic                   state_chg;

  assign state_chg = (state_nxt != state);
  // Done is only honoured while waiting for it; elsewhere it is noise.
  assign capture   = (state == S_WAIT_DONE) && core_done;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and all core/stream outputs; loads and readies only exist
  // in their send state so a stray load can never abort the core.
  always_comb begin
    state_nxt    = state;
    busy         = (state != S_IDLE);
    core_enable  = 1'b0;
    kern_ready   = 1'b0;
    load_kernel  = 1'b0;
    kernel_input = '0;
    img_ready    = 1'b0;
    load_input   = 1'b0;
    image_input  = '0;
    out_valid    = 1'b0;
    out_data     = '0;
    out_last     = 1'b0;
    last_beat    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_START;
      end
      S_START: begin
        // Enable leads the first load so the core is already receiving.
        core_enable = 1'b1;
        state_nxt   = S_SEND_KERNEL;
      end
      S_SEND_KERNEL: begin
        kern_ready   = kernel_ready;
        load_kernel  = kern_valid & kernel_ready;
        kernel_input = kern_data;
        if (load_kernel && (xfer_cnt == TCW'(KK - 1))) state_nxt = S_SEND_IMAGE;
      end
      S_SEND_IMAGE: begin
        img_ready   = input_ready;
        load_input  = img_valid & input_ready;
        image_input = img_data;
        if (load_input && (xfer_cnt == TCW'(NN - 1))) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (core_done) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = frame[idx];
        out_last  = (idx == IW'(OUT_PIX - 1));
        if (out_ready && out_last) begin
          last_beat = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transfer counter: one count per accepted load, cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst)                          xfer_cnt <= '0;
    else if (state_chg)               xfer_cnt <= '0;
    else if (load_kernel | load_input) xfer_cnt <= xfer_cnt + TCW'(1);
  end

  // Output index: advances on each accepted beat, cleared on every state entry.
  always_ff @(posedge clk) begin
    if (rst)                         idx <= '0;
    else if (state_chg)              idx <= '0;
    else if (out_valid && out_ready) idx <= idx + IW'(1);
  end

  // Job-done pulse lands in the cycle after the final beat.
  always_ff @(posedge clk) begin
    if (rst) job_done <= 1'b0;
    else     job_done <= last_beat;
  end

  // Frame snapshot: written only at capture, so core_out may change freely
  // while the frame is being drained.
  for (genvar g = 0; g < OUT_PIX; g++) begin : g_frame
    always_ff @(posedge clk) begin
      if (rst)          frame[g] <= '0;
      else if (capture) frame[g] <= core_out[g];
    end
  end

endmodule

// File: tb/tb_deconv_stream_master.sv
// Randomized scoreboard bench for deconv_stream_master with a simple
// behavioural deconv core model and upstream/downstream stream drivers.
module tb_deconv_stream_master;
  localparam int N  = 2;
  localparam int K  = 3;
  localparam int PW = 8;
  localparam int OP = N*K*N*K;
  localparam int KK = K*K;
  localparam int NN = N*N;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy, job_done;
  logic          kern_valid = 1'b0;
  logic [PW-1:0] kern_data = '0;
  logic          kern_ready;
  logic          img_valid = 1'b0;
  logic [PW-1:0] img_data = '0;
  logic          img_ready;
  logic          core_enable, load_kernel, load_input;
  logic [PW-1:0] kernel_input, image_input;
  logic          kernel_ready = 1'b1;
  logic          input_ready = 1'b1;
  logic          core_done = 1'b0;
  logic [PW-1:0] core_out [0:OP-1];
  logic          out_valid, out_last;
  logic [PW-1:0] out_data;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  deconv_stream_master #(.N(N), .K(K), .PIXEL_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .job_done(job_done),
    .kern_valid(kern_valid), .kern_data(kern_data), .kern_ready(kern_ready),
    .img_valid(img_valid), .img_data(img_data), .img_ready(img_ready),
    .core_enable(core_enable), .load_kernel(load_kernel), .kernel_input(kernel_input),
    .kernel_ready(kernel_ready), .load_input(load_input), .image_input(image_input),
    .input_ready(input_ready), .core_done(core_done), .core_out(core_out),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard queues: expected core load order and expected output frame.
  logic [PW-1:0] exp_k[$];
  logic [PW-1:0] exp_i[$];
  logic [PW-1:0] exp_o[$];

  int   mon_beats = 0;
  int   nload_k = 0;
  int   nload_i = 0;
  int   nen = 0;
  int   jobs_done = 0;
  logic pend_done = 1'b0;
  logic zchk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected at t=%0t", name, $time);
  endtask

  // Monitor: samples everything 2 time units after the falling edge.
  initial forever begin
    logic jd_exp;
    @(negedge clk); #2;
    if (rst) begin
      exp_k.delete(); exp_i.delete(); exp_o.delete();
      mon_beats = 0; nload_k = 0; nload_i = 0; nen = 0;
      pend_done = 1'b0; zchk = 1'b1;
    end else begin
      if (zchk) begin
        chk("reset_ctrl_zero", 32'({busy, job_done, core_enable, load_kernel, load_input,
                                     kern_ready, img_ready, out_valid, out_last}), 32'd0);
        chk("reset_data_zero", 32'({kernel_input, image_input, out_data}), 32'd0);
        zchk = 1'b0;
      end
      jd_exp    = pend_done;
      pend_done = 1'b0;
      if (job_done || jd_exp) chk("job_done", 32'(job_done), 32'(jd_exp));
      if (jd_exp) begin
        chk("n_kload", nload_k, KK);
        chk("n_iload", nload_i, NN);
        chk("n_enable", nen, 1);
        chk("busy_after_done", 32'(busy), 32'd0);
        nload_k = 0; nload_i = 0; nen = 0; mon_beats = 0;
        jobs_done++;
      end
      if (core_enable) begin
        nen++;
        chk("busy_on_enable", 32'(busy), 32'd1);
      end
      if (kern_ready && !kernel_ready) fail("kern_ready_gate");
      if (img_ready && !input_ready) fail("img_ready_gate");
      if (load_kernel) begin
        nload_k++;
        chk("kload_handshake", 32'({kern_valid, kernel_ready}), 32'd3);
        chk("kload_after_enable", nen, 1);
        if (exp_k.size() == 0) fail("kload_extra");
        else chk("kernel_word", 32'(kernel_input), 32'(exp_k.pop_front()));
      end
      if (load_input) begin
        nload_i++;
        chk("iload_handshake", 32'({img_valid, input_ready}), 32'd3);
        if (exp_k.size() != 0) fail("iload_before_kernel_done");
        if (exp_i.size() == 0) fail("iload_extra");
        else chk("image_word", 32'(image_input), 32'(exp_i.pop_front()));
      end
      if (out_valid) begin
        if (exp_o.size() == 0) fail("out_spurious");
        else begin
          chk("out_data", 32'(out_data), 32'(exp_o[0]));
          chk("out_last", 32'(out_last), 32'(mon_beats == OP-1));
          if (out_ready) begin
            void'(exp_o.pop_front());
            mon_beats++;
            if (mon_beats == OP) pend_done = 1'b1;
          end
        end
      end
    end
  end

  // One job: 1 basic, 2 backpressure+random out_ready, 3 bubbly upstream,
  // 4 output stall + core_out corruption, 5 spurious events, 6 reset mid-drain.
  task automatic run_job(input int mode);
    logic [PW-1:0] kw [KK];
    logic [PW-1:0] iw [NN];
    logic [PW-1:0] grid [OP];
    int ki = 0, ii = 0, ck = 0, ci = 0, wait_c = 0, cyc = 0, stall = 0, jd0;
    bit done_sent = 0, sp_done = 0, sp_start = 0, fin = 0, bub;
    for (int i = 0; i < KK; i++) kw[i] = (mode == 1) ? PW'(i + 1) : PW'($urandom);
    for (int i = 0; i < NN; i++) iw[i] = (mode == 1) ? PW'(i + 1) : PW'($urandom);
    for (int j = 0; j < OP; j++) grid[j] = (mode == 1 || mode == 4) ? PW'(j + 10) : PW'($urandom);
    for (int i = 0; i < KK; i++) exp_k.push_back(kw[i]);
    for (int i = 0; i < NN; i++) exp_i.push_back(iw[i]);
    jd0 = jobs_done;
    while (!fin) begin
      @(negedge clk);
      start        = (cyc == 0);
      kernel_ready = (mode == 2) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      input_ready  = kernel_ready;
      bub          = (mode == 3) && (cyc % 2 == 1);
      kern_valid   = (ki < KK) && !bub;
      kern_data    = (ki < KK) ? kw[ki] : '0;
      img_valid    = (ii < NN) && !bub;
      img_data     = (ii < NN) ? iw[ii] : '0;
      core_done    = 1'b0;
      out_ready    = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (mode == 4 && mon_beats == 7 && stall < 5) begin
        out_ready = 1'b0;
        stall++;
      end
      if (mode == 5 && ck == 3 && !sp_done) begin
        core_done = 1'b1;
        for (int j = 0; j < OP; j++) core_out[j] = 8'hAA;
        sp_done = 1;
      end
      if (mode == 5 && ck == KK && ci < 2 && !sp_start) begin
        start = 1'b1;
        sp_start = 1;
      end
      if (ck == KK && ci == NN && !done_sent) begin
        wait_c++;
        if (wait_c == 3) begin
          core_done = 1'b1;
          for (int j = 0; j < OP; j++) begin
            core_out[j] = grid[j];
            exp_o.push_back(grid[j]);
          end
          done_sent = 1;
        end
      end
      if (mode == 4 && done_sent && mon_beats >= 10)
        for (int j = 0; j < OP; j++) core_out[j] = 8'hFF;
      if (mode == 6 && done_sent && mon_beats == 20) begin
        rst = 1'b1;
        out_ready = 1'b0;
        fin = 1;
      end
      #1;
      if (kern_valid && kern_ready) ki++;
      if (img_valid && img_ready) ii++;
      if (load_kernel) ck++;
      if (load_input) ci++;
      cyc++;
      if (jobs_done != jd0) fin = 1;
      if (!fin && cyc > 600) begin
        fail("job_timeout");
        fin = 1;
      end
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0; kern_valid = 1'b0; img_valid = 1'b0;
    core_done = 1'b0; out_ready = 1'b1; kernel_ready = 1'b1; input_ready = 1'b1;
  endtask

  initial begin
    for (int j = 0; j < OP; j++) core_out[j] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_job(1);
    run_job(2);
    run_job(3);
    run_job(4);
    run_job(5);
    run_job(2);
    run_job(6);
    repeat (2) @(negedge clk);
    run_job(1);
    run_job(3);
    repeat (3) @(negedge clk);
    chk("jobs_completed", jobs_done, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
